// File: rtl/i2c_codec_responder_if.sv
// i2c_codec_responder_if: I2C bus pins, write-report strobe and register-file read port
interface i2c_codec_responder_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_oen;
  logic       o_reg_valid;
  logic [6:0] o_reg_addr;
  logic [8:0] o_reg_data;
  logic       o_busy;
  logic [3:0] i_rd_addr;
  logic [8:0] o_rd_data;
  modport slave (
    input  i_scl, i_sda, i_rd_addr,
    output o_sda_oen, o_reg_valid, o_reg_addr, o_reg_data, o_busy, o_rd_data
  );
  modport master (
    output i_scl, i_sda, i_rd_addr,
    input  o_sda_oen, o_reg_valid, o_reg_addr, o_reg_data, o_busy, o_rd_data
  );
endinterface

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: I2C write-only target modelling the WM8731 control port with a 9-bit register file
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 10,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input logic i_clk,
  input logic i_rst_n,
  i2c_codec_responder_if.slave bus
);
  typedef enum logic [3:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, DONE, IGNORE} state_e;
  state_e     state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, b1_q, b1_d;
  logic [6:0] reg_addr_q;
  logic [8:0] reg_data_q;
  logic       reg_valid_q;
  logic [8:0] regs_q [NUM_REGS];
  logic       scl_rise, scl_fall, start, stop, byte_done, commit;
  logic [6:0] c_addr;
  logic [8:0] c_data, rd_data;
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start     = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop      = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign byte_done = scl_fall && cnt_q == 4'd8;
  assign c_addr    = b1_q[7:1];
  assign c_data    = {b1_q[0], sr_q[6:0], sda_q[1]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    b1_d    = b1_q;
    commit  = 1'b0;
    if (stop) state_d = IDLE;
    else if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
    end else begin
      if (scl_rise && state_q inside {ADDR, BYTE1, BYTE2}) begin
        sr_d   = {sr_q[6:0], sda_q[1]};
        cnt_d  = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
        commit = state_q == BYTE2 && cnt_q == 4'd7;
      end
      case (state_q)
        ADDR:  if (byte_done) state_d = (sr_q == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
        BYTE1: if (byte_done) begin
          state_d = ACK_1;
          b1_d    = sr_q;
        end
        BYTE2: if (byte_done) state_d = ACK_2;
        ACK_A, ACK_1: if (scl_fall) begin
          state_d = (state_q == ACK_A) ? BYTE1 : BYTE2;
          cnt_d   = '0;
        end
        ACK_2: if (scl_fall) state_d = DONE;
        default: ;
      endcase
    end
  end
  // Synchronizers reset to the idle-bus level so reset never fabricates an edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scl_q       <= '1;
      sda_q       <= '1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      b1_q        <= '0;
      reg_valid_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      scl_q       <= {scl_q[1:0], bus.i_scl};
      sda_q       <= {sda_q[1:0], bus.i_sda};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      b1_q        <= b1_d;
      reg_valid_q <= commit;
      if (commit) begin
        reg_addr_q <= c_addr;
        reg_data_q <= c_data;
      end
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && c_addr == RESET_REG) regs_q[i] <= '0;
        else if (commit && c_addr == 7'(i)) regs_q[i] <= c_data;
    end
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.i_rd_addr == 4'(i)) rd_data = regs_q[i];
  end
  assign bus.o_sda_oen   = state_q inside {ACK_A, ACK_1, ACK_2};
  assign bus.o_busy      = state_q != IDLE;
  assign bus.o_reg_valid = reg_valid_q;
  assign bus.o_reg_addr  = reg_addr_q;
  assign bus.o_reg_data  = reg_data_q;
  assign bus.o_rd_data   = rd_data;
endmodule
